async_fifo: RTL and testbench
=============================

// Module: async_fifo
// PURPOSE
// - Gray-pointer FIFO buffer, 2^ADDR_WIDTH entries, DATA_WIDTH wide; show-ahead (first-word-fall-through) read port.
// - Pointers cross write->read and read->write through 2-flop synchronisers, so the block can later be split into two clock domains unchanged.
// - Sits between a producer and a slower consumer as an elastic buffer.
// PARAMETERS
// - DATA_WIDTH  8  width of w_data/r_data
// - ADDR_WIDTH  4  log2(depth); depth = 2**ADDR_WIDTH = 16
// PORTS
// - clk     in   1           single clock for all logic
// - rst_n   in   1           reset, asynchronous assert, active-low
// - w_en    in   1           write request
// - w_data  in   DATA_WIDTH  write data, sampled on the clk rising edge when w_en=1 and full=0
// - full    out  1           registered; 1 = no free entry
// - r_en    in   1           read/pop request
// - r_data  out  DATA_WIDTH  head-of-FIFO word, valid whenever empty=0
// - empty   out  1           registered; 1 = no readable entry
// - w_level out  ADDR_WIDTH+1  occupancy; present only with ASYNC_FIFO_LEVEL_EN
// - Interface: one clock; reset is asynchronous and active-low.
// BEHAVIOUR
// - Reset: wptr=rptr=0 (binary and Gray), all synchroniser flops=0, memory cleared, full=0, empty=1, r_data=0.
// - Pointers: ADDR_WIDTH+1 bits binary plus Gray copy; memory addressed by the low ADDR_WIDTH bits; wrap is natural modulo 2^(ADDR_WIDTH+1).
// - Write: if w_en && !full, mem[waddr]<=w_data and wptr increments. A write while full is dropped with no state change.
// - Full flag:
//   - full <= (wgray_next == {~rgray_sync[MSB:MSB-1], rgray_sync[MSB-2:0]}).
//   - Full asserts on the same edge as the 16th write, so a 17th write on the next edge sees full=1.
// - Read: r_data = mem[raddr] combinationally (show-ahead).
//   - If r_en && !empty, rptr increments and r_data shows the next word after that edge.
//   - A read while empty is ignored.
// - Empty flag: empty <= (rgray_next == wgray_sync).
// - Latency:
//   - A write becomes visible (empty falls) 3 clk edges after its write edge: 2 synchroniser stages plus the flag register.
//   - A read frees space (full falls) 3 edges after its read edge.
//   - Flags are pessimistic only; they never signal false data or false space.
// - Simultaneous w_en and r_en are both honoured when their own flags allow; the order of data is preserved.
// - Reset mid-operation: all contents are discarded and the outputs return to their reset values immediately.
// - Synchronisers: two flops each, no combinational logic between the stages.
// CONFIGURATION
// - ASYNC_FIFO_LEVEL_EN:
//   - Defined: adds output w_level = wptr_bin - gray2bin(rgray_sync), registered and reset to 0. It may overstate occupancy by up to the synchroniser latency.
//   - Undefined: the port and its logic are absent, and the rest of the behaviour is identical.
// TESTING
// - After reset, pulse r_en with no writes -> empty stays 1, full=0, pointers unchanged.
// - Write 0x01..0x10 on consecutive edges:
//   - full=1 right after the 16th write.
//   - A 17th write of 0x11 -> full=1 at that edge, and the data is dropped.
// - Then read 16 times -> r_data=0x01..0x10 in order, each visible before its r_en edge; empty=1 after the last read, and 0x11 never appears.
// - Empty FIFO: write 0xA1 -> empty falls within 3 edges and r_data=0xA1 with no r_en asserted.
// - Holding 0xA1,0xA2: assert w_en (0xA3) and r_en on the same edge -> reads return 0xA1, 0xA2, 0xA3 in order, then empty=1.
// - Fill to 8 entries, assert rst_n=0 mid-stream -> full=0 and empty=1 immediately; the next write/read round-trips correctly.

Source files
------------

// File: rtl/async_fifo.sv
// async_fifo: Gray-pointer FIFO, 2**ADDR_WIDTH x DATA_WIDTH, show-ahead read.
// Pointers cross through 2-flop synchronisers so the write and read halves
// can later be moved onto separate clocks without changing the logic.
// Optional occupancy output w_level is compiled in when ASYNC_FIFO_LEVEL_EN
// is defined.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  full,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty
`ifdef ASYNC_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   w_level
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0] r_wbin, r_wgray, r_rbin, r_rgray;
  logic [PW-1:0] r_rsync1, r_rsync2;   // read Gray pointer seen by write side
  logic [PW-1:0] r_wsync1, r_wsync2;   // write Gray pointer seen by read side

  logic          w_wr, w_rd;
  logic [PW-1:0] w_wbin_next, w_wgray_next, w_rbin_next, w_rgray_next;

  // Accepted transfers are qualified by the registered flags only.
  assign w_wr         = w_en & ~full;
  assign w_rd         = r_en & ~empty;
  assign w_wbin_next  = r_wbin + PW'(w_wr);
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
  assign w_rbin_next  = r_rbin + PW'(w_rd);
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  // Show-ahead: head word is always presented combinationally.
  assign r_data = r_mem[r_rbin[ADDR_WIDTH-1:0]];

  // Storage array; cleared on reset so r_data reads 0 while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wbin[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

  // Write pointer and full flag; full is computed on the next pointer so it
  // rises on the same edge as the write that fills the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      full    <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      full    <= (w_wgray_next == {~r_rsync2[PW-1:PW-2], r_rsync2[PW-3:0]});
    end
  end

  // Read pointer and empty flag, same look-ahead scheme as the write side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbin  <= '0;
      r_rgray <= '0;
      empty   <= 1'b1;
    end else begin
      r_rbin  <= w_rbin_next;
      r_rgray <= w_rgray_next;
      empty   <= (w_rgray_next == r_wsync2);
    end
  end

  // Two-flop synchronisers, plain flop-to-flop with nothing in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsync1 <= '0;
      r_rsync2 <= '0;
      r_wsync1 <= '0;
      r_wsync2 <= '0;
    end else begin
      r_rsync1 <= r_rgray;
      r_rsync2 <= r_rsync1;
      r_wsync1 <= r_wgray;
      r_wsync2 <= r_wsync1;
    end
  end

`ifdef ASYNC_FIFO_LEVEL_EN
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Occupancy from the write side's view; may overstate while a read is
  // still crossing the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_level <= '0;
    else        w_level <= w_wbin_next - gray2bin(r_rsync2);
  end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed scoreboard bench for async_fifo (default build).
module tb_async_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       w_en, r_en;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       full, empty;

  logic [7:0] sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_en   (w_en),
    .w_data (w_data),
    .full   (full),
    .r_en   (r_en),
    .r_data (r_data),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_one(input logic [7:0] d, input bit accepted);
    w_en   = 1'b1;
    w_data = d;
    if (accepted) sb.push_back(d);
    step();
    w_en   = 1'b0;
  endtask

  // Wait (bounded) for data, compare head against scoreboard, then pop.
  task automatic read_one(input string tag);
    logic [7:0] exp;
    int         n;
    n = 0;
    while (empty && n < 10) begin
      step();
      n++;
    end
    if (empty) begin
      chk({tag, "_timeout"}, 32'(empty), 32'd0);
    end else begin
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk(tag, 32'(r_data), 32'(exp));
      r_en = 1'b1;
      step();
      r_en = 1'b0;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    w_en   = 1'b0;
    r_en   = 1'b0;
    w_data = 8'h00;
    #22;
    chk("rst_full",  32'(full),   32'd0);
    chk("rst_empty", 32'(empty),  32'd1);
    chk("rst_rdata", 32'(r_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reads on an empty FIFO are ignored.
    for (int i = 0; i < 3; i++) begin
      r_en = 1'b1;
      step();
      chk("idle_rd_empty", 32'(empty), 32'd1);
      chk("idle_rd_full",  32'(full),  32'd0);
    end
    r_en = 1'b0;
    step();

    // Fill with 0x01..0x10; full must rise exactly with the 16th write.
    for (int i = 1; i <= 16; i++) begin
      write_one(8'(i), 1'b1);
      if (i == 15) chk("full_at_15", 32'(full), 32'd0);
    end
    chk("full_at_16", 32'(full), 32'd1);
    write_one(8'h11, 1'b0);
    chk("full_after_17", 32'(full), 32'd1);
    chk("not_empty_when_full", 32'(empty), 32'd0);

    // Drain; 0x11 must not have landed in mem[0].
    for (int i = 0; i < 16; i++) read_one("drain");
    chk("empty_after_drain", 32'(empty),  32'd1);
    chk("no_0x11",           32'(r_data), 32'h01);
    repeat (4) step();
    chk("full_cleared", 32'(full), 32'd0);

    // Single write becomes visible after three edges with no read.
    write_one(8'hA1, 1'b1);
    step();
    step();
    chk("a1_empty_e2", 32'(empty), 32'd1);
    step();
    chk("a1_empty_e3", 32'(empty), 32'd0);
    chk("a1_showahead", 32'(r_data), 32'(sb[0]));

    // Simultaneous read and write with two entries held.
    write_one(8'hA2, 1'b1);
    repeat (3) step();
    chk("sim_head", 32'(r_data), 32'(sb[0]));
    void'(sb.pop_front());
    sb.push_back(8'hA3);
    w_en   = 1'b1;
    w_data = 8'hA3;
    r_en   = 1'b1;
    step();
    w_en = 1'b0;
    r_en = 1'b0;
    read_one("sim_a2");
    read_one("sim_a3");
    chk("sim_empty", 32'(empty), 32'd1);

    // Reset with 8 entries in flight.
    for (int i = 0; i < 8; i++) write_one(8'hB0 + 8'(i), 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_full",  32'(full),   32'd0);
    chk("midrst_empty", 32'(empty),  32'd1);
    chk("midrst_rdata", 32'(r_data), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    write_one(8'hC5, 1'b1);
    read_one("post_rst");
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
